div_arbiter: RTL and testbench

Round-robin controller that shares one mod_div unsigned divider among NREQ requesters. It accepts one request at a time and sequences the divider through start/done. It returns quotient and remainder to the owning requester. Division by zero is resolved locally without starting the divider. A watchdog guards against a divider that never asserts done.

---
 rtl/div_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_div_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//   Round-robin front end that shares one unsigned divider (mod_div) among
//   NREQ requesters. One request is in flight at a time:
//     IDLE  -> pick a requester, latch its operands
//     START -> one-cycle div_start pulse
//     WAIT  -> wait for div_done, bounded by a watchdog
//     RESP  -> one-cycle result strobe to the owner, then advance the pointer
//   Division by zero skips the divider and answers straight from IDLE.
//
// Handshake semantics (all channels):
//   req:  req_valid[i] is held until the cycle in which req_ready[i] is high;
//         the request is taken on that rising edge. req_ready is one-hot,
//         combinational, and only ever non-zero in IDLE.
//   resp: resp_valid is a one-hot, single-cycle strobe with no backpressure;
//         resp_res/resp_rem/resp_dbz/resp_tmo are meaningful only with it.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   req_valid/req_ready      per-requester request handshake
//   req_num/req_den          packed operands, requester i at [i*W +: W]
//   resp_valid               one-hot result strobe to the owner
//   resp_res/resp_rem        quotient / remainder
//   resp_dbz/resp_tmo        divide-by-zero / watchdog-timeout flags
//   busy                     high in every state except IDLE
//   div_start/num/den        to the divider
//   div_res/rem/done         from the divider
//   dbg_state                current FSM state (0 IDLE,1 START,2 WAIT,3 RESP)
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_num,
    input  logic [NREQ*W-1:0] req_den,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_res,
    output logic [W-1:0]      resp_rem,
    output logic              resp_dbz,
    output logic              resp_tmo,
    output logic              busy,
    output logic              div_start,
    output logic [W-1:0]      div_num,
    output logic [W-1:0]      div_den,
    input  logic [W-1:0]      div_res,
    input  logic [W-1:0]      div_rem,
    input  logic              div_done,
    output logic [1:0]        dbg_state
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           tmo_q, tmo_d;
    logic           start_q, start_d;
    logic [W-1:0]   num_q, num_d;
    logic [W-1:0]   den_q, den_d;

    logic           grant_found;
    logic [PW-1:0]  grant_idx;
    logic [W-1:0]   grant_num;
    logic [W-1:0]   grant_den;

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin : arb
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    assign grant_num = req_num[grant_idx*W +: W];
    assign grant_den = req_den[grant_idx*W +: W];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            tmo_q   <= 1'b0;
            start_q <= 1'b0;
            num_q   <= '0;
            den_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            num_q   <= num_d;
            den_q   <= den_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;
        num_d   = num_q;
        den_d   = den_q;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    owner_d = grant_idx;
                    num_d   = grant_num;
                    den_d   = grant_den;
                    // Counter is zero during START, so it equals the number
                    // of cycles elapsed since START while in WAIT.
                    cnt_d   = '0;
                    if (grant_den == '0) begin
                        res_d   = '1;
                        rem_d   = grant_num;
                        dbz_d   = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (div_done) begin
                    res_d   = div_res;
                    rem_d   = div_rem;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                dbz_d   = 1'b0;
                tmo_d   = 1'b0;
                ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state_q == S_IDLE && grant_found) req_ready = NREQ'(1) << grant_idx;
        if (state_q == S_RESP) resp_valid = NREQ'(1) << owner_q;
        busy      = (state_q != S_IDLE);
        dbg_state = state_q;
        resp_res  = res_q;
        resp_rem  = rem_q;
        resp_dbz  = dbz_q;
        resp_tmo  = tmo_q;
        div_start = start_q;
        div_num   = num_q;
        div_den   = den_q;
    end

endmodule

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
//   Self-checking bench for div_arbiter. A behavioural divider stub answers
//   div_start after a random latency (or never, to exercise the watchdog).
//   The arbitration model tracks pending requests and a round-robin pointer;
//   on every modelled grant it pushes the expected response into exp_q, and a
//   separate monitor pops and compares whenever resp_valid is seen.
// -----------------------------------------------------------------------------
module tb_div_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;
  localparam int EW      = 8 + 4*W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_num = '0;
  logic [NREQ*W-1:0] req_den = '0;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_res, resp_rem;
  logic              resp_dbz, resp_tmo, busy;
  logic              div_start;
  logic [W-1:0]      div_num, div_den;
  logic [W-1:0]      div_res = '0;
  logic [W-1:0]      div_rem = '0;
  logic              div_done = 1'b0;
  logic [1:0]        dbg_state;

  div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den),
    .resp_valid(resp_valid), .resp_res(resp_res), .resp_rem(resp_rem),
    .resp_dbz(resp_dbz), .resp_tmo(resp_tmo), .busy(busy),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_res(div_res), .div_rem(div_rem), .div_done(div_done),
    .dbg_state(dbg_state)
  );

  // ---------------- shared bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [NREQ-1:0] pend_valid = '0;
  logic [W-1:0]    pend_num [NREQ];
  logic [W-1:0]    pend_den [NREQ];

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  int model_ptr      = 0;
  bit inflight       = 0;
  bit clear_inflight = 0;
  bit stub_hang      = 0;
  bit withdraw_en    = 0;
  bit stray_en       = 0;
  int last_start_cyc = -1000;
  int last_done_cyc  = -1000;
  int n_served       = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the owner should receive for (num, den).
  function automatic logic [EW-1:0] ref_resp(input int owner, input logic [W-1:0] num,
                                             input logic [W-1:0] den, input bit hang);
    logic [W-1:0] res, rem;
    logic dbz, tmo;
    dbz = 0; tmo = 0;
    if (den == 0) begin
      res = {W{1'b1}}; rem = num; dbz = 1;
    end else if (hang) begin
      res = 0; rem = 0; tmo = 1;
    end else begin
      res = num / den; rem = num % den;
    end
    return {8'(owner), num, den, res, rem, dbz, tmo};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic post_req(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
    pend_num[i]   = n;
    pend_den[i]   = d;
    pend_valid[i] = 1'b1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    acc_q.delete();
    inflight       = 0;
    clear_inflight = 0;
    model_ptr      = 0;
    pend_valid     = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend_valid != 0 || inflight || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: still busy after %0d cycles (pending %b, queued %0d)",
               budget, pend_valid, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".resp_valid"}, resp_valid, 0);
    check({tag, ".resp_res"},   resp_res,   0);
    check({tag, ".resp_rem"},   resp_rem,   0);
    check({tag, ".resp_dbz"},   resp_dbz,   0);
    check({tag, ".resp_tmo"},   resp_tmo,   0);
    check({tag, ".div_start"},  div_start,  0);
    check({tag, ".div_num"},    div_num,    0);
    check({tag, ".div_den"},    div_den,    0);
    check({tag, ".busy"},       busy,       0);
    check({tag, ".state"},      dbg_state,  0);
    check({tag, ".req_ready"},  req_ready,  0);
  endtask

  // ---------------- requester driver + arbitration model ----------------
  initial begin
    logic [NREQ-1:0] exp_rdy;
    int g, idx, w;
    forever begin
      @(negedge clk);
      if (clear_inflight) begin
        inflight       = 0;
        clear_inflight = 0;
      end
      if (withdraw_en && $urandom_range(0, 31) == 0) begin
        w = $urandom_range(0, NREQ-1);
        pend_valid[w] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]       = pend_valid[i];
        req_num[i*W +: W]  = pend_num[i];
        req_den[i*W +: W]  = pend_den[i];
      end
      #2;
      if (rst) begin
        check("busy", busy, inflight);
        exp_rdy = '0;
        g = -1;
        if (!inflight) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (model_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
          exp_q.push_back(ref_resp(g, req_num[g*W +: W], req_den[g*W +: W], stub_hang));
          acc_q.push_back(cyc);
          pend_valid[g] = 1'b0;
          inflight      = 1;
          model_ptr     = (g + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- divider stub ----------------
  initial begin
    bit           stub_busy;
    int           stub_cnt;
    logic [W-1:0] stub_num, stub_den;
    stub_busy = 0;
    stub_cnt  = 0;
    stub_num  = 0;
    stub_den  = 1;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      div_res  = W'($urandom);
      div_rem  = W'($urandom);
      if (!rst) begin
        stub_busy = 0;
      end else if (stub_busy) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          div_done      = 1'b1;
          div_res       = stub_num / stub_den;
          div_rem       = stub_num % stub_den;
          stub_busy     = 0;
          last_done_cyc = cyc;
        end
      end else if (stray_en && !stub_hang && $urandom_range(0, 7) == 0) begin
        // junk done while nothing is outstanding; must be ignored
        div_done = 1'b1;
      end
      #2;
      if (rst && div_start) begin
        check("div_start_while_busy", stub_busy, 0);
        last_start_cyc = cyc;
        if (!stub_hang) begin
          stub_busy = 1;
          stub_cnt  = $urandom_range(1, 8);
          stub_num  = div_num;
          stub_den  = div_den;
        end
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    bit              last_resp;
    logic [7:0]      e_owner;
    logic [W-1:0]    e_num, e_den, e_res, e_rem;
    logic            e_dbz, e_tmo;
    logic [NREQ-1:0] oh;
    int              acc;
    last_resp = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        last_resp = 0;
      end else if (resp_valid != 0) begin
        check("resp_single_cycle", last_resp, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid %b with nothing expected", resp_valid);
        end else begin
          {e_owner, e_num, e_den, e_res, e_rem, e_dbz, e_tmo} = exp_q.pop_front();
          acc = acc_q.pop_front();
          oh = '0;
          oh[e_owner] = 1'b1;
          check("resp_valid", resp_valid, oh);
          check("resp_res", resp_res, e_res);
          check("resp_rem", resp_rem, e_rem);
          check("resp_dbz", resp_dbz, e_dbz);
          check("resp_tmo", resp_tmo, e_tmo);
          check("div_operands_hold", {div_num, div_den}, {e_num, e_den});
          check("busy_in_resp", busy, 1);
          if (e_dbz) begin
            check("dbz_latency", cyc - acc, 1);
            check("dbz_no_start", (last_start_cyc < acc), 1);
          end else begin
            check("start_latency", last_start_cyc - acc, 1);
            if (e_tmo) check("tmo_latency", cyc - last_start_cyc, TIMEOUT);
            else       check("done_latency", cyc - last_done_cyc, 1);
          end
          n_served++;
          clear_inflight = 1;
        end
        last_resp = 1;
      end else begin
        last_resp = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n0, i;
    logic [W-1:0] rn, rd;
    for (int k = 0; k < NREQ; k++) begin
      pend_num[k] = '0;
      pend_den[k] = '0;
    end

    // power-on reset
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;
    stray_en = 1;

    // single request: 17/5 -> 3 r 2
    post_req(0, 8'd17, 8'd5);
    drain(200);

    // divide by zero: 9/0 -> FF r 9, no divider start
    post_req(2, 8'd9, 8'd0);
    drain(200);

    // fairness wrap: ptr is now 3, so requester 1 beats requester 2
    post_req(1, 8'd40, 8'd6);
    post_req(2, 8'd41, 8'd7);
    drain(300);

    // contention from reset: all four pending when reset releases
    @(negedge clk);
    #3 rst = 1'b0;
    flush_model();
    post_req(0, 8'd200, 8'd3);
    post_req(1, 8'd55,  8'd10);
    post_req(2, 8'd7,   8'd9);
    post_req(3, 8'd255, 8'd16);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    drain(500);

    // watchdog: divider never answers
    stub_hang = 1;
    post_req(1, 8'd77, 8'd5);
    drain(300);
    stub_hang = 0;
    post_req(1, 8'd200, 8'd9);
    drain(200);

    // reset in the middle of WAIT
    stub_hang = 1;
    n0 = last_start_cyc;
    post_req(3, 8'd50, 8'd3);
    i = 0;
    while (last_start_cyc == n0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("start_before_reset", (last_start_cyc != n0), 1);
    repeat (10) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("mid_wait");
    flush_model();
    stub_hang = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    post_req(0, 8'd100, 8'd7);
    drain(200);

    // randomized traffic, including withdrawn requests and zero divisors
    withdraw_en = 1;
    for (int t = 0; t < 120; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i  = $urandom_range(0, NREQ-1);
      rn = W'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (!pend_valid[i]) post_req(i, rn, rd);
    end
    withdraw_en = 0;
    drain(5000);

    check("served_any", (n_served > 20), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global bound on run time
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: run did not finish by %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
